stall_controller: RTL and testbench
===================================

// Module: stall_controller
// PURPOSE
//   Pipeline hazard/stall controller for the 16-bit core. Generates the hold controls
//   (1 = preserve current value) consumed by the PC and pipeline-register preserve muxes.
//   Also generates the bubble and flush controls for load-use hazards, taken branches,
//   multi-cycle memory waits and HALT.
//   Hold outputs are Mealy: a function of the registered state and the current inputs,
//   so a stall takes effect in the same cycle the hazard is seen.
// PARAMETERS
//   MEM_WAIT  2  stall cycles per memory access (0 = mem_req ignored); range 0..2**CNT_W
//   CNT_W     4  width of the wait counter
// PORTS
//   clk             in   1   rising-edge clock
//   rst_n           in   1   asynchronous active-low reset
//   id_rs_a         in   3   ID-stage source register A
//   id_rs_b         in   3   ID-stage source register B
//   id_uses_a       in   1   ID instruction reads id_rs_a
//   id_uses_b       in   1   ID instruction reads id_rs_b
//   ex_rd           in   3   EX-stage destination register
//   ex_is_load      in   1   EX instruction is a load writing ex_rd
//   mem_req         in   1   MEM stage holds a load/store; stays high while frozen
//   branch_taken    in   1   EX resolved a taken branch
//   halt            in   1   HLT instruction is in WB
//   pc_preserve     out  1   hold PC
//   ifid_preserve   out  1   hold IF/ID register
//   idex_preserve   out  1   hold ID/EX register
//   exmem_preserve  out  1   hold EX/MEM register
//   idex_bubble     out  1   load NOP into ID/EX
//   ifid_flush      out  1   load NOP into IF/ID
//   halted          out  1   core halted
//   stall_count     out  16  cycles with pc_preserve=1 outside HALT; saturates at 16'hFFFF
// BEHAVIOUR
//   States: RUN, WAIT, HALT. Reset (async, rst_n=0): state=RUN, cnt=0, stall_count=0,
//     halted=0. While rst_n=0 all outputs are forced to 0.
//   Event priority: halt > memory freeze > branch flush > load-use.
//   HALT entry: halt=1 in any state -> all four preserves=1 that cycle; next state=HALT.
//   HALT: all preserves=1, bubble/flush=0, halted=1. Exit only via reset.
//   Memory freeze (RUN, mem_req=1, MEM_WAIT>0):
//     - this cycle: all four preserves=1; bubble/flush=0.
//     - next: state=WAIT, cnt=MEM_WAIT-1.
//   WAIT, cnt!=0: all four preserves=1; cnt decrements.
//   WAIT, cnt==0 (advance cycle): mem_req ignored; branch and load-use evaluated as in
//     RUN; next state=RUN.
//   Result: exactly MEM_WAIT freeze cycles; the pipeline advances at cycle t+MEM_WAIT.
//   Branch flush (no freeze): ifid_flush=1, idex_bubble=1, all preserves=0.
//     PC loads the branch target.
//   Load-use (no freeze, no branch):
//     - hazard: ex_is_load && ((id_uses_a && id_rs_a==ex_rd) || (id_uses_b && id_rs_b==ex_rd)).
//     - pc_preserve=1, ifid_preserve=1, idex_bubble=1; idex/exmem preserves=0.
//     - exactly one cycle, stateless; the hazard clears when the bubble enters EX.
//     - r0 gets no special case.
//   Simultaneous mem_req+branch_taken: freeze wins. EX is frozen, so branch_taken
//     re-asserts and the flush happens in the advance cycle.
//   stall_count increments on each clock edge where pc_preserve=1 and state!=HALT
//     (includes the HALT-entry cycle); it holds at 16'hFFFF.
//   Reset mid-WAIT aborts the wait. After release, a still-high mem_req starts a
//     full new freeze.
// TESTING
//   1 Load-use, ex_is_load=1, ex_rd=3, id_rs_a=3, id_uses_a=1
//     -> pc/ifid_preserve=1, idex_bubble=1, idex/exmem_preserve=0 for 1 cycle;
//        stall_count 0->1.
//   2 MEM_WAIT=2, mem_req=1 at t, held through t+2
//     -> all preserves=1 at t and t+1, 0 at t+2; no restart at t+2; stall_count=2.
//   3 branch_taken=1 with a load-use match in the same cycle
//     -> ifid_flush=1, idex_bubble=1, pc_preserve=0, stall_count unchanged.
//   4 mem_req and branch_taken at t (MEM_WAIT=2)
//     -> freeze at t and t+1; ifid_flush=1 and idex_bubble=1 at t+2.
//   5 halt=1 during WAIT -> all preserves=1 that cycle; halted=1 from the next cycle on;
//     mem_req ignored; stall_count frozen.
//   6 rst_n=0 mid-WAIT -> all outputs 0 immediately.
//     Release with mem_req=1 -> a full MEM_WAIT-cycle freeze again.
//     Preload via 65536 freeze cycles -> stall_count stays 16'hFFFF.

Source files
------------

// File: rtl/stall_controller.sv
// Purpose  : pipeline hazard/stall controller; drives PC and pipeline-register hold muxes,
//            plus bubble/flush for load-use hazards, taken branches, memory waits and HALT.
// Latency  : hold/bubble/flush are Mealy (same cycle as the hazard); halted is registered.
// Backpres.: a memory access freezes all four stages for exactly MEM_WAIT cycles.
// Ports    : i_clk/i_rst_n clock and async active-low reset
//            i_id_rs_a/b, i_id_uses_a/b  ID-stage source registers and their use flags
//            i_ex_rd, i_ex_is_load       EX-stage destination and load flag
//            i_mem_req                   MEM stage holds a load/store (held while frozen)
//            i_branch_taken, i_halt      taken branch in EX, HLT in WB
//            o_*_preserve                hold controls (1 = keep current value)
//            o_idex_bubble, o_ifid_flush NOP insertion into ID/EX and IF/ID
//            o_halted, o_stall_count     halted flag, saturating count of PC-hold cycles
module stall_controller #(
   parameter int MEM_WAIT = 2,
   parameter int CNT_W    = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [2:0]  i_id_rs_a,
   input  logic [2:0]  i_id_rs_b,
   input  logic        i_id_uses_a,
   input  logic        i_id_uses_b,
   input  logic [2:0]  i_ex_rd,
   input  logic        i_ex_is_load,
   input  logic        i_mem_req,
   input  logic        i_branch_taken,
   input  logic        i_halt,
   output logic        o_pc_preserve,
   output logic        o_ifid_preserve,
   output logic        o_idex_preserve,
   output logic        o_exmem_preserve,
   output logic        o_idex_bubble,
   output logic        o_ifid_flush,
   output logic        o_halted,
   output logic [15:0] o_stall_count
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam bit              MEM_EN   = (MEM_WAIT > 0);
   localparam int              LOAD_I   = MEM_EN ? (MEM_WAIT - 1) : 0;
   // The access cycle itself is the first freeze cycle, so the counter holds the
   // number of freeze cycles still to come after it.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [15:0]       r_stall_count;

   logic w_hazard;
   logic w_pc;
   logic w_ifid;
   logic w_idex;
   logic w_exmem;
   logic w_bubble;
   logic w_flush;

   // r0 is treated like any other register: a load to r0 still stalls its consumer.
   assign w_hazard = i_ex_is_load &&
                     ((i_id_uses_a && (i_id_rs_a == i_ex_rd)) ||
                      (i_id_uses_b && (i_id_rs_b == i_ex_rd)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Priority: halt > memory freeze > branch flush > load-use.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pc        = 1'b0;
      w_ifid      = 1'b0;
      w_idex      = 1'b0;
      w_exmem     = 1'b0;
      w_bubble    = 1'b0;
      w_flush     = 1'b0;

      if (r_state == ST_HALT) begin
         {w_pc, w_ifid, w_idex, w_exmem} = 4'b1111;
      end else if (i_halt) begin
         {w_pc, w_ifid, w_idex, w_exmem} = 4'b1111;
         w_state_nxt = ST_HALT;
      end else if ((r_state == ST_RUN) && i_mem_req && MEM_EN) begin
         {w_pc, w_ifid, w_idex, w_exmem} = 4'b1111;
         w_state_nxt = ST_WAIT;
         w_cnt_nxt   = CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
         {w_pc, w_ifid, w_idex, w_exmem} = 4'b1111;
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end else begin
         // RUN without a new access, or the WAIT advance cycle where the still-high
         // mem_req belongs to the access that just completed and is ignored.
         if (r_state == ST_WAIT) begin
            w_state_nxt = ST_RUN;
         end
         if (i_branch_taken) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
         end else if (w_hazard) begin
            w_pc     = 1'b1;
            w_ifid   = 1'b1;
            w_bubble = 1'b1;
         end
      end
   end

   // Counts PC-hold cycles outside HALT; the HALT-entry cycle still counts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_count <= '0;
      end else if (w_pc && (r_state != ST_HALT) && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   // All outputs are forced low while reset is asserted, including the
   // combinational ones driven straight from the inputs.
   assign o_pc_preserve    = i_rst_n & w_pc;
   assign o_ifid_preserve  = i_rst_n & w_ifid;
   assign o_idex_preserve  = i_rst_n & w_idex;
   assign o_exmem_preserve = i_rst_n & w_exmem;
   assign o_idex_bubble    = i_rst_n & w_bubble;
   assign o_ifid_flush     = i_rst_n & w_flush;
   assign o_halted         = i_rst_n & (r_state == ST_HALT);
   assign o_stall_count    = i_rst_n ? r_stall_count : 16'h0000;

endmodule

// File: tb/tb_stall_controller.sv
// Purpose  : self-checking bench for stall_controller (vector table, corner sequences, random vs model).
// Latency  : outputs checked 1 ns after inputs change on the falling edge.
// Backpres.: none; the bench drives every input each cycle.
module tb_stall_controller;

   localparam int MW = 2;

   // Output vector order: {pc, ifid, idex, exmem, bubble, flush, halted}
   localparam logic [6:0] IDLE = 7'b0000_000;
   localparam logic [6:0] FRZ  = 7'b1111_000;
   localparam logic [6:0] LU   = 7'b1100_100;
   localparam logic [6:0] BR   = 7'b0000_110;
   localparam logic [6:0] HLT  = 7'b1111_001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  id_rs_a, id_rs_b, ex_rd;
   logic        id_uses_a, id_uses_b, ex_is_load;
   logic        mem_req, branch_taken, halt;
   logic        pc_p, ifid_p, idex_p, exmem_p, bubble, flush, halted;
   logic [15:0] stall_count;
   logic [6:0]  outs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stall_controller #(.MEM_WAIT(MW), .CNT_W(4)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_id_rs_a        (id_rs_a),
      .i_id_rs_b        (id_rs_b),
      .i_id_uses_a      (id_uses_a),
      .i_id_uses_b      (id_uses_b),
      .i_ex_rd          (ex_rd),
      .i_ex_is_load     (ex_is_load),
      .i_mem_req        (mem_req),
      .i_branch_taken   (branch_taken),
      .i_halt           (halt),
      .o_pc_preserve    (pc_p),
      .o_ifid_preserve  (ifid_p),
      .o_idex_preserve  (idex_p),
      .o_exmem_preserve (exmem_p),
      .o_idex_bubble    (bubble),
      .o_ifid_flush     (flush),
      .o_halted         (halted),
      .o_stall_count    (stall_count)
   );

   assign outs = {pc_p, ifid_p, idex_p, exmem_p, bubble, flush, halted};

   typedef struct {
      logic [2:0] a;
      logic [2:0] b;
      logic       ua;
      logic       ub;
      logic [2:0] rd;
      logic       ld;
      logic       br;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic clear_in();
      id_rs_a = 3'd0; id_rs_b = 3'd0; ex_rd = 3'd7;
      id_uses_a = 1'b0; id_uses_b = 1'b0; ex_is_load = 1'b0;
      mem_req = 1'b0; branch_taken = 1'b0; halt = 1'b0;
   endtask

   task automatic set_lu();
      id_rs_a = 3'd3; id_uses_a = 1'b1; ex_rd = 3'd3; ex_is_load = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_in();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model state: freeze cycles left in the current access, advance-cycle
   // flag, halted flag and the saturating stall counter.
   bit         m_halted;
   int         m_rem;
   bit         m_adv;
   int         m_cnt;

   initial begin
      logic [6:0] e;
      bit         fr;
      bit         hz;

      tbl[0] = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, LU};   // A matches load
      tbl[1] = '{3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, LU};   // B matches load
      tbl[2] = '{3'd4, 3'd4, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, IDLE}; // match but unused
      tbl[3] = '{3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, IDLE}; // match, not a load
      tbl[4] = '{3'd2, 3'd6, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, IDLE}; // no register match
      tbl[5] = '{3'd0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, LU};   // r0 not special
      tbl[6] = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, BR};   // branch beats load-use
      tbl[7] = '{3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, BR};   // plain branch

      // Reset state with a live hazard on the inputs: everything must be low.
      clear_in();
      set_lu();
      rst_n = 1'b0;
      #2;
      chk("reset_outs", {9'd0, outs}, 16'd0);
      chk("reset_cnt", stall_count, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_in();

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         id_rs_a = tbl[i].a; id_rs_b = tbl[i].b;
         id_uses_a = tbl[i].ua; id_uses_b = tbl[i].ub;
         ex_rd = tbl[i].rd; ex_is_load = tbl[i].ld; branch_taken = tbl[i].br;
         #1;
         chk($sformatf("vec%0d", i), {9'd0, outs}, {9'd0, tbl[i].exp});
      end

      // Load-use: one stall cycle, counter 0 -> 1.
      do_reset();
      @(negedge clk); set_lu(); #1;
      chk("lu_outs", {9'd0, outs}, {9'd0, LU});
      @(negedge clk); clear_in(); #1;
      chk("lu_after", {9'd0, outs}, {9'd0, IDLE});
      chk("lu_cnt", stall_count, 16'd1);

      // Memory freeze held through the advance cycle: no restart there.
      do_reset();
      @(negedge clk); mem_req = 1'b1; #1;
      chk("mem_t0", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); #1;
      chk("mem_t1", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); #1;
      chk("mem_t2", {9'd0, outs}, {9'd0, IDLE});
      @(negedge clk); mem_req = 1'b0; #1;
      chk("mem_cnt", stall_count, 16'd2);

      // Branch plus load-use: flush, no stall, counter unchanged.
      @(negedge clk); set_lu(); branch_taken = 1'b1; #1;
      chk("br_lu_outs", {9'd0, outs}, {9'd0, BR});
      @(negedge clk); clear_in(); #1;
      chk("br_lu_cnt", stall_count, 16'd2);

      // Simultaneous mem_req and branch: freeze first, flush in the advance cycle.
      do_reset();
      @(negedge clk); mem_req = 1'b1; branch_taken = 1'b1; #1;
      chk("mb_t0", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); #1;
      chk("mb_t1", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); #1;
      chk("mb_t2", {9'd0, outs}, {9'd0, BR});
      @(negedge clk); clear_in();

      // Halt arriving during WAIT.
      do_reset();
      @(negedge clk); mem_req = 1'b1; #1;
      chk("hw_t0", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); halt = 1'b1; #1;
      chk("hw_entry", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); halt = 1'b0; set_lu(); branch_taken = 1'b1; #1;
      chk("hw_halted", {9'd0, outs}, {9'd0, HLT});
      chk("hw_cnt", stall_count, 16'd2);
      repeat (5) @(negedge clk);
      #1;
      chk("hw_hold", {9'd0, outs}, {9'd0, HLT});
      chk("hw_cnt_hold", stall_count, 16'd2);

      // Reset mid-WAIT, then a fresh full freeze with mem_req still high.
      do_reset();
      @(negedge clk); mem_req = 1'b1; #1;
      chk("rw_t0", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); rst_n = 1'b0; #1;
      chk("rw_rst_outs", {9'd0, outs}, {9'd0, IDLE});
      chk("rw_rst_cnt", stall_count, 16'd0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("rw_n0", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); #1;
      chk("rw_n1", {9'd0, outs}, {9'd0, FRZ});
      @(negedge clk); #1;
      chk("rw_n2", {9'd0, outs}, {9'd0, IDLE});
      chk("rw_cnt", stall_count, 16'd2);

      // Saturation: a continuous load-use stall for more than 65535 cycles.
      do_reset();
      @(negedge clk); set_lu();
      repeat (65540) @(posedge clk);
      @(negedge clk); #1;
      chk("sat_cnt", stall_count, 16'hFFFF);
      chk("sat_outs", {9'd0, outs}, {9'd0, LU});

      // Randomized run against the reference model.
      do_reset();
      m_halted = 1'b0; m_rem = 0; m_adv = 1'b0; m_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst_n        = ($urandom_range(0, 99) >= 2);
         halt         = ($urandom_range(0, 299) == 0);
         mem_req      = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 4) == 0);
         id_rs_a      = 3'($urandom_range(0, 3));
         id_rs_b      = 3'($urandom_range(0, 3));
         ex_rd        = 3'($urandom_range(0, 3));
         id_uses_a    = 1'($urandom_range(0, 1));
         id_uses_b    = 1'($urandom_range(0, 1));
         ex_is_load   = 1'($urandom_range(0, 1));
         #1;
         fr = 1'b0;
         e  = IDLE;
         if (!rst_n) begin
            m_halted = 1'b0; m_rem = 0; m_adv = 1'b0; m_cnt = 0;
         end else begin
            hz = ex_is_load && ((id_uses_a && id_rs_a == ex_rd) ||
                                (id_uses_b && id_rs_b == ex_rd));
            if (!m_halted && !halt) begin
               if (m_rem > 0) begin
                  fr = 1'b1;
               end else if (!m_adv && mem_req && MW > 0) begin
                  m_rem = MW;
                  fr = 1'b1;
               end
            end
            if (m_halted)          e = HLT;
            else if (halt || fr)   e = FRZ;
            else if (branch_taken) e = BR;
            else if (hz)           e = LU;
         end
         chk("rnd_outs", {9'd0, outs}, {9'd0, e});
         chk("rnd_cnt", stall_count, 16'(m_cnt));
         if (rst_n) begin
            if (e[6] && !m_halted && m_cnt < 65535) m_cnt++;
            if (fr) begin
               m_rem--;
               m_adv = (m_rem == 0);
            end else begin
               m_adv = 1'b0;
            end
            if (halt) m_halted = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
